// File: rtl/fir_feed_pkg.sv
// Shared types and sizing helpers for the FIR sample feeder slice.
package fir_feed_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LOW  = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  localparam int DEF_DEPTH    = 8;
  localparam int DEF_MAX_WAIT = 64;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int wait_width(input int max_wait);
    return $clog2(max_wait + 1);
  endfunction

  localparam int DEF_CNT_W  = cnt_width(DEF_DEPTH);
  localparam int DEF_WAIT_W = wait_width(DEF_MAX_WAIT);

endpackage

// File: rtl/fir_sample_feeder_if.sv
// Sample stream in, single-sample issue to the FIR MAC, FIR completion back.
interface fir_sample_feeder_if #(
  parameter int INPUT_WIDTH = 8
) ();

  logic signed [INPUT_WIDTH-1:0] s_data;
  logic                          s_valid;
  logic                          s_ready;
  logic signed [INPUT_WIDTH-1:0] fir_data;
  logic                          fir_data_flag;
  logic                          fir_done;

  modport master (
    output s_data, s_valid, fir_done,
    input  s_ready, fir_data, fir_data_flag
  );

  modport slave (
    input  s_data, s_valid, fir_done,
    output s_ready, fir_data, fir_data_flag
  );

endinterface

// File: rtl/fir_sample_feeder_fifo.sv
// Small synchronous FIFO with a combinational head read and occupancy count.
module sync_fifo import fir_feed_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic                          pop,
  input  logic signed [WIDTH-1:0]       wdata,
  output logic signed [WIDTH-1:0]       rdata,
  output logic [cnt_width(DEPTH)-1:0]   count,
  output logic                          full,
  output logic                          empty
);

  localparam int AW = $clog2(DEPTH);

  logic signed [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;

  // Storage is not reset; contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers incoming samples and hands them to the sequential FIR one at a time,
// waiting for each busy/done cycle to finish before issuing the next.
module fir_sample_feeder import fir_feed_pkg::*; #(
  parameter int INPUT_WIDTH = 8,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int MAX_WAIT    = DEF_MAX_WAIT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fir_sample_feeder_if.slave          bus,
  output logic [cnt_width(DEPTH)-1:0] fifo_count,
  output logic                        err_timeout
);

  localparam int WAIT_W = wait_width(MAX_WAIT);

  state_t                        state;
  logic [WAIT_W-1:0]             wait_cnt;
  logic signed [INPUT_WIDTH-1:0] head;
  logic                          push;
  logic                          pop;
  logic                          full;
  logic                          empty;

  assign bus.s_ready = rst_n && !full;
  assign push        = bus.s_valid && bus.s_ready;
  assign pop         = (state == IDLE) && !empty && bus.fir_done;

  sync_fifo #(
    .WIDTH (INPUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (bus.s_data),
    .rdata (head),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  // WAIT_LOW tolerates one cycle of done still high, since the FIR only
  // reacts to the flag on the edge after it is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      wait_cnt          <= '0;
      bus.fir_data      <= '0;
      bus.fir_data_flag <= 1'b0;
      err_timeout       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus.fir_data      <= head;
            bus.fir_data_flag <= 1'b1;
            wait_cnt          <= '0;
            state             <= WAIT_LOW;
          end else begin
            bus.fir_data_flag <= 1'b0;
          end
        end
        WAIT_LOW: begin
          bus.fir_data_flag <= 1'b0;
          if (!bus.fir_done) begin
            wait_cnt <= '0;
            state    <= WAIT_DONE;
          end else if (wait_cnt != '0) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= WAIT_W'(1);
          end
        end
        WAIT_DONE: begin
          bus.fir_data_flag <= 1'b0;
          if (bus.fir_done) begin
            state <= IDLE;
          end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          bus.fir_data_flag <= 1'b0;
          state             <= IDLE;
        end
      endcase
    end
  end

endmodule
